// File: rtl/cache_refill_ctrl_if.sv
// Cache refill controller bus bundle.
// Groups the miss, replacement-policy, memory, data-array and tag-array
// signals of cache_refill_ctrl. The master modport is the controller side;
// the slave modport is the side of the surrounding cache and memory system.
// Optional macro REFILL_FWD_EN adds the critical-word forwarding outputs.
interface cache_refill_ctrl_if #(
  parameter int DEPTH      = 256,
  parameter int WAY_NUM    = 4,
  parameter int TAG_WIDTH  = 20,
  parameter int DATA_WIDTH = 32,
  parameter int BEATS      = 4,
  parameter int ADDR_WIDTH = $clog2(DEPTH),
  parameter int WAY_WIDTH  = $clog2(WAY_NUM),
  parameter int BEAT_WIDTH = $clog2(BEATS)
) ();

  // miss request
  logic                            miss_valid;
  logic                            miss_ready;
  logic [ADDR_WIDTH-1:0]           miss_index;
  logic [TAG_WIDTH-1:0]            miss_tag;

  // replacement policy lookup and update
  logic [ADDR_WIDTH-1:0]           repl_index;
  logic [WAY_WIDTH-1:0]            repl_way;
  logic                            repl_upd_en;
  logic [ADDR_WIDTH-1:0]           repl_upd_index;
  logic [WAY_WIDTH-1:0]            repl_upd_way;

  // next-level memory
  logic                            mem_req_valid;
  logic                            mem_req_ready;
  logic [TAG_WIDTH+ADDR_WIDTH-1:0] mem_req_addr;
  logic                            mem_resp_valid;
  logic [DATA_WIDTH-1:0]           mem_resp_data;
  logic                            mem_resp_last;

  // data and tag array writes
  logic                            wr_en;
  logic [ADDR_WIDTH-1:0]           wr_index;
  logic [WAY_WIDTH-1:0]            wr_way;
  logic [BEAT_WIDTH-1:0]           wr_beat;
  logic [DATA_WIDTH-1:0]           wr_data;
  logic                            tag_wr_en;
  logic [TAG_WIDTH-1:0]            tag_wr_data;

  // status
  logic                            done_valid;
  logic                            err;

`ifdef REFILL_FWD_EN
  // forwarding of each refill beat to the requester
  logic                            fwd_valid;
  logic [BEAT_WIDTH-1:0]           fwd_beat;
  logic [DATA_WIDTH-1:0]           fwd_data;
`endif

  modport master (
    input  miss_valid, miss_index, miss_tag,
    output miss_ready,
    output repl_index, repl_upd_en, repl_upd_index, repl_upd_way,
    input  repl_way,
    output mem_req_valid, mem_req_addr,
    input  mem_req_ready, mem_resp_valid, mem_resp_data, mem_resp_last,
    output wr_en, wr_index, wr_way, wr_beat, wr_data,
    output tag_wr_en, tag_wr_data,
`ifdef REFILL_FWD_EN
    output fwd_valid, fwd_beat, fwd_data,
`endif
    output done_valid, err
  );

  modport slave (
    output miss_valid, miss_index, miss_tag,
    input  miss_ready,
    input  repl_index, repl_upd_en, repl_upd_index, repl_upd_way,
    output repl_way,
    input  mem_req_valid, mem_req_addr,
    output mem_req_ready, mem_resp_valid, mem_resp_data, mem_resp_last,
    input  wr_en, wr_index, wr_way, wr_beat, wr_data,
    input  tag_wr_en, tag_wr_data,
`ifdef REFILL_FWD_EN
    input  fwd_valid, fwd_beat, fwd_data,
`endif
    input  done_valid, err
  );

endinterface

// File: rtl/cache_refill_ctrl.sv
// Cache line refill controller.
// Accepts one miss at a time, asks the replacement policy for a victim way,
// issues a single line read to memory, writes the returned beats into the
// data array, writes the tag with the final beat and finally marks the
// refilled way MRU. The beat counter alone decides where the line ends;
// the memory's last flag is only cross-checked and a disagreement raises a
// sticky error.
// Optional macro REFILL_FWD_EN: adds fwd_valid/fwd_beat/fwd_data, which
// mirror every accepted refill beat in the same cycle.
module cache_refill_ctrl #(
  parameter int DEPTH      = 256,
  parameter int WAY_NUM    = 4,
  parameter int TAG_WIDTH  = 20,
  parameter int DATA_WIDTH = 32,
  parameter int BEATS      = 4,
  parameter int ADDR_WIDTH = $clog2(DEPTH),
  parameter int WAY_WIDTH  = $clog2(WAY_NUM),
  parameter int BEAT_WIDTH = $clog2(BEATS)
) (
  input  logic                 clk,
  input  logic                 rst,
  cache_refill_ctrl_if.master  bus
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    VICTIM = 3'd1,
    REQ    = 3'd2,
    RECV   = 3'd3,
    DONE   = 3'd4
  } state_t;

  localparam logic [BEAT_WIDTH-1:0] LAST_BEAT = BEAT_WIDTH'(BEATS - 1);

  state_t                  state_reg, state_next;
  logic [ADDR_WIDTH-1:0]   index_reg;
  logic [TAG_WIDTH-1:0]    tag_reg;
  logic [WAY_WIDTH-1:0]    way_reg;
  logic [BEAT_WIDTH-1:0]   beat_reg, beat_next;
  logic                    err_reg, err_next;
  logic                    is_last;

  // The counter, not mem_resp_last, defines the final beat of the line.
  assign is_last = (beat_reg == LAST_BEAT);

  // FSM state, beat counter and sticky error register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      beat_reg  <= '0;
      err_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      beat_reg  <= beat_next;
      err_reg   <= err_next;
    end
  end

  // Miss latch (on acceptance) and victim capture (the cycle after the
  // policy saw repl_index, when its registered repl_way is valid).
  always_ff @(posedge clk) begin
    if (rst) begin
      index_reg <= '0;
      tag_reg   <= '0;
      way_reg   <= '0;
    end else begin
      if (state_reg == IDLE && bus.miss_valid) begin
        index_reg <= bus.miss_index;
        tag_reg   <= bus.miss_tag;
      end
      if (state_reg == VICTIM) begin
        way_reg <= bus.repl_way;
      end
    end
  end

  // Next-state logic and all outputs; every data field stays zero unless
  // its enable is high, and nothing is enabled while rst is asserted.
  always_comb begin
    state_next         = state_reg;
    beat_next          = beat_reg;
    err_next           = err_reg;

    bus.miss_ready     = 1'b0;
    bus.repl_index     = (state_reg == IDLE) ? bus.miss_index : index_reg;
    bus.repl_upd_en    = 1'b0;
    bus.repl_upd_index = '0;
    bus.repl_upd_way   = '0;
    bus.mem_req_valid  = 1'b0;
    bus.mem_req_addr   = '0;
    bus.wr_en          = 1'b0;
    bus.wr_index       = '0;
    bus.wr_way         = '0;
    bus.wr_beat        = '0;
    bus.wr_data        = {DATA_WIDTH{1'b0}};
    bus.tag_wr_en      = 1'b0;
    bus.tag_wr_data    = {TAG_WIDTH{1'b0}};
    bus.done_valid     = 1'b0;
    bus.err            = err_reg;
`ifdef REFILL_FWD_EN
    bus.fwd_valid      = 1'b0;
    bus.fwd_beat       = '0;
    bus.fwd_data       = {DATA_WIDTH{1'b0}};
`endif

    if (!rst) begin
      case (state_reg)
        IDLE: begin
          bus.miss_ready = 1'b1;
          if (bus.miss_valid) begin
            state_next = VICTIM;
          end
        end

        // Single cycle: the policy's registered answer is captured here.
        VICTIM: begin
          state_next = REQ;
        end

        // Request and address come from latched state, so they hold
        // steady for as long as memory stalls.
        REQ: begin
          bus.mem_req_valid = 1'b1;
          bus.mem_req_addr  = {tag_reg, index_reg};
          if (bus.mem_req_ready) begin
            beat_next  = '0;
            state_next = RECV;
          end
        end

        // Each valid beat is written straight through to the data array.
        RECV: begin
          if (bus.mem_resp_valid) begin
            bus.wr_en    = 1'b1;
            bus.wr_index = index_reg;
            bus.wr_way   = way_reg;
            bus.wr_beat  = beat_reg;
            bus.wr_data  = bus.mem_resp_data;
`ifdef REFILL_FWD_EN
            bus.fwd_valid = 1'b1;
            bus.fwd_beat  = beat_reg;
            bus.fwd_data  = bus.mem_resp_data;
`endif
            beat_next = beat_reg + 1'b1;
            if (bus.mem_resp_last != is_last) begin
              err_next = 1'b1;
            end
            if (is_last) begin
              bus.tag_wr_en   = 1'b1;
              bus.tag_wr_data = tag_reg;
              state_next      = DONE;
            end
          end
        end

        DONE: begin
          bus.done_valid     = 1'b1;
          bus.repl_upd_en    = 1'b1;
          bus.repl_upd_index = index_reg;
          bus.repl_upd_way   = way_reg;
          state_next         = IDLE;
        end

        default: begin
          state_next = IDLE;
        end
      endcase
    end
  end

endmodule
